vga_sync_meas: RTL and testbench
================================

Name: vga_sync_meas

Overview:
Receive-side counterpart of the team's sync/display timing generator. Samples one incoming sync line (hsync or vsync) and measures its period and pulse width in clk cycles. Detects pulse polarity and declares lock after consecutive stable periods. Used for mode detection and self-check of generated VGA timing, and for video-input front ends.

Parameters:
CW, 12, width of all cycle counters and measurement outputs.
LOCK_CNT, 4, consecutive matching periods required to assert lock (1..15).
TOL, 2, allowed absolute difference in cycles between successive period/high-time samples.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_sync  in  1  raw sync input, asynchronous to clk, either polarity
o_total  out  CW  measured period in clk cycles
o_pulse  out  CW  measured sync pulse width (active phase) in clk cycles
o_pol  out  1  1 = active-high pulse, 0 = active-low
o_locked  out  1  measurement stable
o_upd  out  1  one-cycle strobe: outputs refreshed

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous, active-low.
- Reset values: all outputs 0, synchronizer flops 0, state IDLE, counters 0.
- Input path: 2-flop synchronizer, then previous-value flop. rise = s & ~s_d, fall = ~s & s_d. Edge-to-detect latency is 3 clk.
- Counter cnt:
  - Set to 1 on the rise cycle; otherwise cnt+1.
  - Saturates at 2^CW-1.
  - On fall: H <= cnt (high time).
  - On rise: P <= cnt (period), then cnt <= 1.
- Derived values, evaluated on the rise cycle with the new P:
  - L = P-H.
  - pulse = min(H, L).
  - pol = (H <= L); a tie gives active-high.
- Match condition: |P - P_prev| <= TOL and |H - H_prev| <= TOL. P_prev/H_prev update on every rise in TRACK/LOCKED.
- FSM:
  - IDLE: first rise -> ACQ (cnt starts).
  - ACQ: next rise (full period seen, fall seen in between) -> TRACK, match_cnt = 0. Rise without intervening fall is treated as a glitch: stay ACQ, restart cnt.
  - TRACK: each rise with match increments match_cnt; a mismatch clears it to 0. When match_cnt reaches LOCK_CNT -> LOCKED.
  - LOCKED: on each matching rise, o_total <= P, o_pulse <= pulse, o_pol <= pol, o_upd = 1 on the following cycle. The first load happens on the lock transition itself. A mismatch -> TRACK, o_locked = 0, match_cnt = 0, outputs hold their last values.
- o_locked = 1 exactly while in LOCKED, registered.
- Timeout: cnt reaching 2^CW-1 in any state other than IDLE -> IDLE. o_locked = 0; o_total/o_pulse/o_pol are cleared to 0 the same cycle.
- Simultaneous timeout and rise: timeout wins.
- Reset mid-lock: immediate return to reset values; relock requires ACQ + LOCK_CNT periods.
- Arithmetic: unsigned CW-bit; the |a-b| difference computed at CW+1 bits.

Optional Feature:
VGA_SYNC_MEAS_GLITCH_FILTER_EN
- Defined: a 3-sample majority filter is inserted after the synchronizer. Single-cycle glitches are rejected; edge latency becomes 5 clk. Measured P/H are unchanged for clean input.
- Undefined: no filter; latency is 3 clk; a 1-cycle glitch produces edges and causes a mismatch.

Decomposition:
- Shared package vga_pkg:
  - FSM state encoding (IDLE, ACQ, TRACK, LOCKED).
  - Default CW.
  - Standard mode constants (e.g. 1280-mode H total 1688 / sync 112), also usable by the generator.
- One natural sub-module: vga_sync_edge, covering the synchronizer, the optional majority filter, and rise/fall outputs.

Test Plan:
- Active-low hsync, period 1688, low 112, after reset -> o_locked rises after ACQ + 4 periods; o_total=1688, o_pulse=112, o_pol=0; o_upd pulses once per subsequent period.
- Same timing but active-high (high 112) -> o_pulse=112, o_pol=1, o_total=1688.
- Locked, then period jitter of ±1 cycle -> stays locked. One period of 1692 (+4) -> o_locked drops, outputs hold 1688/112, relock after 4 matching periods.
- Locked, input held constant -> o_locked=0 and outputs cleared exactly 4095 cycles after the last rise is counted; state IDLE.
- rst_n pulsed low mid-LOCKED -> all outputs 0 asynchronously; relock takes ACQ + 4 periods.
- 1-cycle high glitch inside the low phase:
  - With the macro: lock is kept and values are unchanged.
  - Without the macro: lock is lost.

Source files
------------

// File: rtl/vga_pkg.sv
// Purpose: shared types and constants for VGA sync generation and measurement.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: measurement FSM state encoding, default counter width, standard mode timings.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } meas_state_t;

    localparam int VGA_CW = 12;

    // 1280x1024@60 line and frame timing
    localparam int H1280_TOTAL = 1688;
    localparam int H1280_SYNC  = 112;
    localparam int V1280_TOTAL = 1066;
    localparam int V1280_SYNC  = 3;

    // 640x480@60 line and frame timing
    localparam int H640_TOTAL  = 800;
    localparam int H640_SYNC   = 96;
    localparam int V640_TOTAL  = 525;
    localparam int V640_SYNC   = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Purpose: bring a raw asynchronous sync line into clk and flag its edges.
// Latency: 3 clk input edge to rise/fall detect (5 clk with the glitch filter).
// Backpressure: none, free-running sampler.
// Ports: clk, rst_n (async active-low), i_sync raw input; rise/fall one-cycle pulses.
// Macro VGA_SYNC_MEAS_GLITCH_FILTER_EN inserts a 3-sample majority filter.
module vga_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic rise,
    output logic fall
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= i_sync;
            sync_q2 <= sync_q1;
        end
    end

`ifdef VGA_SYNC_MEAS_GLITCH_FILTER_EN
    // Majority of the current and two previous samples: a single-cycle
    // spike never gets two votes, so it cannot move the filtered level.
    logic [1:0] hist;
    logic       filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b00;
            filt <= 1'b0;
        end else begin
            hist <= {hist[0], sync_q2};
            filt <= (sync_q2 & hist[0]) | (sync_q2 & hist[1]) | (hist[0] & hist[1]);
        end
    end

    assign level = filt;
`else
    assign level = sync_q2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;
    assign fall = ~level & level_d;

endmodule

// File: rtl/vga_sync_meas.sv
// Purpose: measure period, pulse width and polarity of one sync line; declare lock.
// Latency: outputs load 3 clk after the input rising edge (5 with glitch filter); o_upd one cycle later.
// Backpressure: none, results are presented as registered values plus an o_upd strobe.
// Ports: clk, rst_n (async active-low), i_sync; o_total/o_pulse/o_pol results, o_locked, o_upd.
// Macro VGA_SYNC_MEAS_GLITCH_FILTER_EN (in vga_sync_edge) enables single-cycle glitch rejection.
module vga_sync_meas
    import vga_pkg::*;
#(
    parameter int CW       = VGA_CW,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sync,
    output logic [CW-1:0] o_total,
    output logic [CW-1:0] o_pulse,
    output logic          o_pol,
    output logic          o_locked,
    output logic          o_upd
);

    localparam int            CW1     = CW + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW:0]   TOL_V   = CW1'(TOL);
    localparam logic [4:0]    LOCK_V  = 5'(LOCK_CNT);

    logic rise;
    logic fall;

    vga_sync_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sync (i_sync),
        .rise   (rise),
        .fall   (fall)
    );

    meas_state_t   state;
    meas_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] h_q;
    logic [CW-1:0] p_prev;
    logic [CW-1:0] h_prev;
    logic          fall_seen;
    logic [3:0]    match_cnt;

    logic          timeout;
    logic          match;
    logic [CW-1:0] low_new;
    logic [CW-1:0] pulse_new;
    logic          pol_new;
    logic [CW:0]   dp;
    logic [CW:0]   dh;

    logic          load_out;
    logic          clr_out;
    logic          upd_prev;
    logic          mc_clr;
    logic          mc_inc;

    // On a rise cycle cnt still holds the just-finished period.
    assign timeout   = (state != IDLE) && (cnt == CNT_MAX);
    assign low_new   = cnt - h_q;
    assign pol_new   = (h_q <= low_new);
    assign pulse_new = pol_new ? h_q : low_new;

    assign dp = (cnt >= p_prev) ? ({1'b0, cnt} - {1'b0, p_prev}) : ({1'b0, p_prev} - {1'b0, cnt});
    assign dh = (h_q >= h_prev) ? ({1'b0, h_q} - {1'b0, h_prev}) : ({1'b0, h_prev} - {1'b0, h_q});
    assign match = (dp <= TOL_V) && (dh <= TOL_V);

    always_comb begin
        state_nx = state;
        load_out = 1'b0;
        clr_out  = 1'b0;
        upd_prev = 1'b0;
        mc_clr   = 1'b0;
        mc_inc   = 1'b0;
        if (timeout) begin
            // Timeout has priority over a coincident rise.
            state_nx = IDLE;
            clr_out  = 1'b1;
        end else if (rise) begin
            unique case (state)
                IDLE: begin
                    state_nx = ACQ;
                end
                ACQ: begin
                    // A rise with no fall since the last one is a glitch; stay and restart.
                    if (fall_seen) begin
                        state_nx = TRACK;
                        upd_prev = 1'b1;
                        mc_clr   = 1'b1;
                    end
                end
                TRACK: begin
                    upd_prev = 1'b1;
                    if (!match) begin
                        mc_clr = 1'b1;
                    end else if (({1'b0, match_cnt} + 5'd1) == LOCK_V) begin
                        state_nx = LOCKED;
                        load_out = 1'b1;
                    end else begin
                        mc_inc = 1'b1;
                    end
                end
                LOCKED: begin
                    upd_prev = 1'b1;
                    if (match) begin
                        load_out = 1'b1;
                    end else begin
                        state_nx = TRACK;
                        mc_clr   = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            h_q       <= '0;
            p_prev    <= '0;
            h_prev    <= '0;
            fall_seen <= 1'b0;
            match_cnt <= '0;
            o_total   <= '0;
            o_pulse   <= '0;
            o_pol     <= 1'b0;
            o_locked  <= 1'b0;
            o_upd     <= 1'b0;
        end else begin
            if (rise) begin
                cnt <= CW'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (fall) begin
                h_q <= cnt;
            end

            if (rise) begin
                fall_seen <= 1'b0;
            end else if (fall) begin
                fall_seen <= 1'b1;
            end

            if (upd_prev) begin
                p_prev <= cnt;
                h_prev <= h_q;
            end

            if (mc_clr) begin
                match_cnt <= '0;
            end else if (mc_inc) begin
                match_cnt <= match_cnt + 1'b1;
            end

            if (clr_out) begin
                o_total <= '0;
                o_pulse <= '0;
                o_pol   <= 1'b0;
            end else if (load_out) begin
                o_total <= cnt;
                o_pulse <= pulse_new;
                o_pol   <= pol_new;
            end

            o_upd    <= load_out;
            o_locked <= (state_nx == LOCKED);
        end
    end

endmodule

// File: tb/tb_vga_sync_meas.sv
// Purpose: directed plus randomized checks of vga_sync_meas against a waveform-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_sync_meas;

    localparam int CW       = 12;
    localparam int LOCK_CNT = 4;
    localparam int TOL      = 2;
    localparam int TMO      = 4095;
    localparam int CHK_AT   = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_sync;
    logic [CW-1:0] o_total;
    logic [CW-1:0] o_pulse;
    logic          o_pol;
    logic          o_locked;
    logic          o_upd;

    always #5 clk = ~clk;

    vga_sync_meas #(
        .CW       (CW),
        .LOCK_CNT (LOCK_CNT),
        .TOL      (TOL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sync   (i_sync),
        .o_total  (o_total),
        .o_pulse  (o_pulse),
        .o_pol    (o_pol),
        .o_locked (o_locked),
        .o_upd    (o_upd)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int upd_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (o_upd === 1'b1) upd_cnt <= upd_cnt + 1;
    end

    // Reference model: works on the input waveform as driven, one cycle at a time.
    int m_lvl, m_started, m_fall, m_have_prev, m_seg, m_hi, m_pp, m_hp, m_run;
    int m_locked, m_total, m_pulse, m_pol;
    int m_upd = 0;

    function automatic int adiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_started = 0; m_fall = 0; m_have_prev = 0;
        m_seg = 0; m_hi = 0; m_pp = 0; m_hp = 0; m_run = 0;
        m_locked = 0; m_total = 0; m_pulse = 0; m_pol = 0;
    endtask

    task automatic model_cycle(input int v);
        int lo;
        bit ok;
        if (v == 1 && m_lvl == 0) begin
            if (m_started == 0) begin
                m_started = 1;
            end else if (m_have_prev == 0) begin
                if (m_fall == 1) begin
                    m_have_prev = 1; m_pp = m_seg; m_hp = m_hi; m_run = 0;
                end
            end else begin
                ok = (adiff(m_seg, m_pp) <= TOL) && (adiff(m_hi, m_hp) <= TOL);
                m_pp = m_seg;
                m_hp = m_hi;
                if (ok) m_run++;
                else begin
                    m_run = 0;
                    m_locked = 0;
                end
                if (m_run >= LOCK_CNT) begin
                    lo       = m_seg - m_hi;
                    m_locked = 1;
                    m_total  = m_seg;
                    m_pulse  = (m_hi <= lo) ? m_hi : lo;
                    m_pol    = (m_hi <= lo) ? 1 : 0;
                    m_upd++;
                end
            end
            m_fall = 0;
            m_seg  = 1;
            m_hi   = 1;
        end else begin
            if (v == 0 && m_lvl == 1) m_fall = 1;
            m_seg++;
            if (m_fall == 0) m_hi += v;
        end
        m_lvl = v;
        if (m_started == 1 && m_seg >= TMO) begin
            m_started = 0; m_have_prev = 0; m_run = 0;
            m_locked = 0; m_total = 0; m_pulse = 0; m_pol = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_locked"}, 32'(o_locked), m_locked);
        chk({tag, "_total"},  32'(o_total),  m_total);
        chk({tag, "_pulse"},  32'(o_pulse),  m_pulse);
        chk({tag, "_pol"},    32'(o_pol),    m_pol);
        chk({tag, "_upd"},    upd_cnt,       m_upd);
    endtask

    // Drive level v for one cycle; the model sees mv (differs only for filtered glitches).
    task automatic step(input logic v, input int mv);
        i_sync = v;
        model_cycle(mv);
        @(posedge clk);
        @(negedge clk);
        if (m_seg == CHK_AT) compare_all("period");
    endtask

    task automatic drive(input logic v, input int n, input int mv);
        for (int i = 0; i < n; i++) step(v, mv);
    endtask

    task automatic period_seg(input int hi, input int lo);
        drive(1'b1, hi, 1);
        drive(1'b0, lo, 0);
    endtask

    int gmv;
    int glitch_keep;
    int k;
    int in_win;
    int p, w, act_hi, jt, inact;

    initial begin
`ifdef VGA_SYNC_MEAS_GLITCH_FILTER_EN
        gmv = 0; glitch_keep = 1;
`else
        gmv = 1; glitch_keep = 0;
`endif
        rst_n  = 1'b0;
        i_sync = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_total",  32'(o_total),  0);
        chk("rst_pulse",  32'(o_pulse),  0);
        chk("rst_pol",    32'(o_pol),    0);
        chk("rst_upd",    32'(o_upd),    0);
        rst_n = 1'b1;

        // Active-low 1280 line: 1576 high, 112 low.
        for (int i = 0; i < 5; i++) period_seg(1576, 112);
        chk("lock_not_before_acq4", 32'(o_locked), 0);
        drive(1'b1, 20, 1);
        chk("lock_after_acq4", 32'(o_locked), 1);
        drive(1'b1, 1556, 1);
        drive(1'b0, 112, 0);
        for (int i = 0; i < 2; i++) period_seg(1576, 112);
        chk("low_total", 32'(o_total), 1688);
        chk("low_pulse", 32'(o_pulse), 112);
        chk("low_pol",   32'(o_pol),   0);
        chk("low_upd_per_period", upd_cnt, 3);

        // +-1 jitter keeps lock; last jittered period is nominal.
        for (int i = 0; i < 6; i++) begin
            jt = (i == 5) ? 0 : int'($urandom_range(0, 2)) - 1;
            period_seg(1576 + jt, 112);
        end
        drive(1'b1, 20, 1);
        chk("jitter_keeps_lock", 32'(o_locked), 1);
        drive(1'b1, 1560, 1);               // this period is 1692
        drive(1'b0, 112, 0);
        drive(1'b1, 20, 1);
        chk("bump_drops_lock", 32'(o_locked), 0);
        chk("bump_hold_total", 32'(o_total), 1688);
        chk("bump_hold_pulse", 32'(o_pulse), 112);
        drive(1'b1, 1556, 1);
        drive(1'b0, 112, 0);
        for (int i = 0; i < 4; i++) period_seg(1576, 112);
        drive(1'b1, 20, 1);
        chk("bump_relock", 32'(o_locked), 1);
        drive(1'b1, 1556, 1);
        drive(1'b0, 112, 0);

        // Active-high: 112 high, 1576 low.
        for (int i = 0; i < 7; i++) period_seg(112, 1576);
        chk("high_locked", 32'(o_locked), 1);
        chk("high_total",  32'(o_total),  1688);
        chk("high_pulse",  32'(o_pulse),  112);
        chk("high_pol",    32'(o_pol),    1);

        // Reset while locked.
        drive(1'b1, 50, 1);
        rst_n  = 1'b0;
        i_sync = 1'b0;
        model_reset();
        #1;
        chk("arst_locked", 32'(o_locked), 0);
        chk("arst_total",  32'(o_total),  0);
        chk("arst_pulse",  32'(o_pulse),  0);
        chk("arst_pol",    32'(o_pol),    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) period_seg(1576, 112);
        chk("arst_no_early_lock", 32'(o_locked), 0);
        drive(1'b1, 20, 1);
        chk("arst_relock", 32'(o_locked), 1);
        drive(1'b1, 1556, 1);
        drive(1'b0, 112, 0);

        // One-cycle high glitch inside the low pulse.
        drive(1'b1, 1576, 1);
        drive(1'b0, 50, 0);
        drive(1'b1, 1, gmv);
        drive(1'b0, 61, 0);
        drive(1'b1, 20, 1);
        chk("glitch_lock", 32'(o_locked), glitch_keep);
        chk("glitch_total", 32'(o_total), 1688);
        chk("glitch_pulse", 32'(o_pulse), 112);
        drive(1'b1, 1556, 1);
        drive(1'b0, 112, 0);

        // Random modes with occasional large jumps.
        for (int r = 0; r < 4; r++) begin
            p      = int'($urandom_range(60, 200));
            w      = int'($urandom_range(10, p / 2));
            act_hi = int'($urandom_range(0, 1));
            for (int s = 0; s < 8; s++) begin
                jt    = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 1));
                inact = p - w + jt;
                if (act_hi == 1) period_seg(w, inact);
                else period_seg(inact, w);
            end
        end

        // Lock on a short line, then hold the input high until timeout.
        for (int i = 0; i < 7; i++) period_seg(200, 40);
        chk("pre_timeout_lock", 32'(o_locked), 1);
        k = 0;
        do begin
            step(1'b1, 1);
            k++;
        end while (o_locked === 1'b1 && k < 4400);
        in_win = (k >= TMO && k <= TMO + 8) ? 1 : 0;
        chk("timeout_window", in_win, 1);
        chk("timeout_total", 32'(o_total), 0);
        chk("timeout_pulse", 32'(o_pulse), 0);
        chk("timeout_pol",   32'(o_pol),   0);
        compare_all("after_timeout");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
